// File: rtl/vote_recorder_pkg.sv
// rtl/vote_recorder_pkg.sv - shared state encodings, defaults and helpers for the vote recorder
package vote_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACK    = 2'd2,
    ST_RESULT = 2'd3
  } rec_state_e;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  localparam int DEFAULT_ACK_CYCLES = 100000000;
  localparam int DEFAULT_CNT_W      = 8;

  // True when exactly one bit of the (zero-extended) vote vector is set.
  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/vote_recorder_hold_timer.sv
// rtl/vote_recorder_hold_timer.sv - loadable down-counter that flags the last held cycle
module vote_recorder_hold_timer #(
  parameter int CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(CYCLES);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == ONE);

endmodule

// File: rtl/vote_recorder.sv
// rtl/vote_recorder.sv - one-vote-per-ballot recorder with per-candidate tallies and result view
module vote_recorder
  import vote_recorder_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int ACK_CYCLES = DEFAULT_ACK_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ballot_arm,
  input  logic [NUM_CAND-1:0] valid_vote,
  input  logic                mode,
  input  logic [2:0]          sel,
  output logic                ready,
  output logic [NUM_CAND-1:0] ack_led,
  output logic                vote_err,
  output logic [CNT_W-1:0]    tally_out,
  output logic                sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rec_state_e          state_q, state_d;
  logic                ready_q, ready_d;
  logic [NUM_CAND-1:0] ack_led_q, ack_led_d;
  logic                vote_err_q, vote_err_d;
  logic [CNT_W-1:0]    tally_out_q, tally_out_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    tally_q [NUM_CAND];
  logic [CNT_W-1:0]    tally_d [NUM_CAND];

  logic                timer_load;
  logic                timer_done;
  logic                vote_single;
  logic [CNT_W-1:0]    tally_sel;

  vote_recorder_hold_timer #(
    .CYCLES (ACK_CYCLES)
  ) u_hold_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .done  (timer_done)
  );

  assign vote_single = is_one_hot(8'(valid_vote));

  // Tally shown in result mode; indices beyond the candidate count read as zero.
  always_comb begin
    tally_sel = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (sel == 3'(i)) begin
        tally_sel = tally_q[i];
      end
    end
  end

  // Next-state, tally update and next-output computation.
  always_comb begin
    state_d     = state_q;
    ack_led_d   = ack_led_q;
    vote_err_d  = 1'b0;
    sat_d       = sat_q;
    tally_d     = tally_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RESULT) begin
          state_d = ST_RESULT;
        end else if (ballot_arm) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (vote_single) begin
          for (int i = 0; i < NUM_CAND; i++) begin
            if (valid_vote[i]) begin
              tally_d[i] = (tally_q[i] == CNT_MAX) ? CNT_MAX : tally_q[i] + 1'b1;
              if (tally_d[i] == CNT_MAX) begin
                sat_d = 1'b1;
              end
            end
          end
          ack_led_d  = valid_vote;
          timer_load = 1'b1;
          state_d    = ST_ACK;
        end else if (valid_vote != '0) begin
          vote_err_d = 1'b1;
        end else if (mode == MODE_RESULT) begin
          state_d = ST_RESULT;
        end
      end
      ST_ACK: begin
        if (timer_done) begin
          ack_led_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_RESULT: begin
        if (mode == MODE_VOTE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d     = (state_d == ST_ARMED);
    tally_out_d = (state_d == ST_RESULT) ? tally_sel : '0;
  end

  // State, tallies and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      ack_led_q   <= '0;
      vote_err_q  <= 1'b0;
      tally_out_q <= '0;
      sat_q       <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) begin
        tally_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      ack_led_q   <= ack_led_d;
      vote_err_q  <= vote_err_d;
      tally_out_q <= tally_out_d;
      sat_q       <= sat_d;
      for (int i = 0; i < NUM_CAND; i++) begin
        tally_q[i] <= tally_d[i];
      end
    end
  end

  assign ready     = ready_q;
  assign ack_led   = ack_led_q;
  assign vote_err  = vote_err_q;
  assign tally_out = tally_out_q;
  assign sat       = sat_q;

endmodule
